// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI command sequencer: FSM encoding, status word
// layout and the SPI engine status fields it consumes.
package spi_seq_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    localparam int SEQ_BUSY_BIT     = 31;
    localparam int RB_COUNT_LSB     = 16;
    localparam int CMD_COUNT_LSB    = 8;
    localparam int TIMEOUT_ERR_BIT  = 2;
    localparam int RB_OVERFLOW_BIT  = 1;
    localparam int CMD_OVERFLOW_BIT = 0;

    localparam int SPI_BUSY_BIT = 31;
    localparam int SPI_RB_WIDTH = 24;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with a combinational head read; pushes when full and pops
// when empty are ignored, and fullness uses the count from before the edge.
module spi_seq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spi_command_sequencer.sv
// Feeds queued 32-bit command words to the SPI engine one at a time, waits for
// each transfer and collects the 24-bit readbacks into a second FIFO.
module spi_command_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int GAP_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cmdWrite,
    input  logic [31:0]             cmdData,
    input  logic                    rbRead,
    output logic [SPI_RB_WIDTH-1:0] rbData,
    input  logic                    clearErrors,
    output logic [31:0]             seqStatus,
    output logic                    spiStrobe,
    output logic [31:0]             spiCommand,
    input  logic [31:0]             spiStatus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]              state;
    logic [31:0]             timer;
    logic [31:0]             cmd_head;
    logic [CW-1:0]           cmd_count;
    logic [CW-1:0]           rb_count;
    logic                    cmd_full;
    logic                    cmd_empty;
    logic                    rb_full;
    logic                    rb_empty_unused;
    logic                    rb_push;
    logic [SPI_RB_WIDTH-1:0] rb_wdata;
    logic                    cmd_overflow;
    logic                    rb_overflow;
    logic                    timeout_err;
    logic                    engine_busy;
    logic                    start_issue;
    logic                    timeout_hit;
    logic                    unused_status_bits;

    assign engine_busy        = spiStatus[SPI_BUSY_BIT];
    assign unused_status_bits = ^spiStatus[SPI_BUSY_BIT-1:SPI_RB_WIDTH];
    assign start_issue        = (state == S_IDLE) && enable && !cmd_empty && !engine_busy;
    assign timeout_hit        = (state == S_WAIT_BUSY) && !engine_busy
                                && (timer == 32'(BUSY_TIMEOUT - 1));

    spi_seq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmdWrite),
        .wdata (cmdData),
        .pop   (start_issue),
        .head  (cmd_head),
        .count (cmd_count),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    spi_seq_fifo #(.WIDTH(SPI_RB_WIDTH), .DEPTH(DEPTH)) rb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rb_push),
        .wdata (rb_wdata),
        .pop   (rbRead),
        .head  (rbData),
        .count (rb_count),
        .full  (rb_full),
        .empty (rb_empty_unused)
    );

    // The readback push is registered: it lands the cycle after busy is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            spiStrobe  <= 1'b0;
            spiCommand <= '0;
            rb_push    <= 1'b0;
            rb_wdata   <= '0;
        end else begin
            spiStrobe <= start_issue;
            rb_push   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_issue) begin
                        spiCommand <= cmd_head;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (engine_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timeout_hit) begin
                        timer <= '0;
                        state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!engine_busy) begin
                        rb_push  <= 1'b1;
                        rb_wdata <= spiStatus[SPI_RB_WIDTH-1:0];
                        timer    <= '0;
                        state    <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (timer == 32'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A flag event in the same cycle as clearErrors leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_overflow <= 1'b0;
            rb_overflow  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cmd_overflow <= (cmdWrite && cmd_full) ? 1'b1 : (clearErrors ? 1'b0 : cmd_overflow);
            rb_overflow  <= (rb_push && rb_full)   ? 1'b1 : (clearErrors ? 1'b0 : rb_overflow);
            timeout_err  <= timeout_hit            ? 1'b1 : (clearErrors ? 1'b0 : timeout_err);
        end
    end

    always_comb begin
        seqStatus                           = '0;
        seqStatus[SEQ_BUSY_BIT]             = (state != S_IDLE) || !cmd_empty;
        seqStatus[RB_COUNT_LSB +: 8]        = 8'(rb_count);
        seqStatus[CMD_COUNT_LSB +: 8]       = 8'(cmd_count);
        seqStatus[TIMEOUT_ERR_BIT]          = timeout_err;
        seqStatus[RB_OVERFLOW_BIT]          = rb_overflow;
        seqStatus[CMD_OVERFLOW_BIT]         = cmd_overflow;
    end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed bench for spi_command_sequencer with a simple SPI engine model that
// holds busy for a fixed number of clocks after each strobe.
module tb_spi_command_sequencer;

    localparam int DEPTH        = 16;
    localparam int GAP_CYCLES   = 8;
    localparam int BUSY_TIMEOUT = 4;
    localparam int XFER_CLOCKS  = 40;

    typedef struct {
        logic [31:0] cmd;
        logic [23:0] rb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0;
    logic        cmdWrite = 1'b0;
    logic [31:0] cmdData = '0;
    logic        rbRead = 1'b0;
    logic [23:0] rbData;
    logic        clearErrors = 1'b0;
    logic [31:0] seqStatus;
    logic        spiStrobe;
    logic [31:0] spiCommand;
    logic [31:0] spiStatus;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          busy_cnt = 0;
    logic        never_busy = 1'b0;
    logic        stuck_busy = 1'b0;
    logic [23:0] rb_value = '0;
    logic [23:0] rb_table [64];
    logic [31:0] strobe_cmd [64];
    int          strobe_cyc [64];

    spi_command_sequencer #(
        .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmdWrite    (cmdWrite),
        .cmdData     (cmdData),
        .rbRead      (rbRead),
        .rbData      (rbData),
        .clearErrors (clearErrors),
        .seqStatus   (seqStatus),
        .spiStrobe   (spiStrobe),
        .spiCommand  (spiCommand),
        .spiStatus   (spiStatus)
    );

    always #5 clk = ~clk;

    // Engine model: busy rises the clock after the strobe and stays high
    // XFER_CLOCKS clocks; the readback is taken from rb_table by strobe index.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spiStrobe) begin
            if (strobe_cnt < 64) begin
                strobe_cmd[strobe_cnt] <= spiCommand;
                strobe_cyc[strobe_cnt] <= cyc;
                rb_value               <= rb_table[strobe_cnt];
            end
            strobe_cnt <= strobe_cnt + 1;
            if (!never_busy) begin
                busy_cnt <= XFER_CLOCKS;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign spiStatus = {(busy_cnt > 0) || stuck_busy, 7'b0, rb_value};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] data,
                                 input logic rd, input logic clr);
        cmdWrite    = wr;
        cmdData     = data;
        rbRead      = rd;
        clearErrors = clr;
        step();
        cmdWrite    = 1'b0;
        rbRead      = 1'b0;
        clearErrors = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (!seqStatus[31] && !spiStatus[31]) break;
            step();
        end
        checkOutput(name, {31'b0, seqStatus[31]}, 32'd0);
    endtask

    task automatic waitStrobe(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (strobe_cnt >= target) break;
            step();
        end
        checkRange(name, strobe_cnt, target, target);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [3];
        int   base;
        int   t2base;

        vecs[0] = '{cmd: 32'h8000_1234, rb: 24'hA5A5A5};
        vecs[1] = '{cmd: 32'h9012_3456, rb: 24'h5A5A5A};
        vecs[2] = '{cmd: 32'h1100_00AB, rb: 24'h00C3C3};
        for (int i = 0; i < 64; i++) begin
            rb_table[i] = 24'h300000 + 24'(i);
        end

        rst = 1'b1;
        step();
        step();
        checkOutput("reset_status", seqStatus, 32'd0);
        checkOutput("reset_rbdata", {8'b0, rbData}, 32'd0);
        checkOutput("reset_strobe", {31'b0, spiStrobe}, 32'd0);
        checkOutput("reset_command", spiCommand, 32'd0);
        rst = 1'b0;
        step();

        // Three commands, strobe two cycles after the first write.
        base = strobe_cnt;
        for (int i = 0; i < 3; i++) begin
            rb_table[base + i] = vecs[i].rb;
        end
        enable = 1'b1;
        applyStimulus(1'b1, vecs[0].cmd, 1'b0, 1'b0);
        checkOutput("t1_strobe_n1", {31'b0, spiStrobe}, 32'd0);
        applyStimulus(1'b1, vecs[1].cmd, 1'b0, 1'b0);
        checkOutput("t1_strobe_n2", {31'b0, spiStrobe}, 32'd1);
        checkOutput("t1_cmd_n2", spiCommand, vecs[0].cmd);
        applyStimulus(1'b1, vecs[2].cmd, 1'b0, 1'b0);
        checkOutput("t1_strobe_n3", {31'b0, spiStrobe}, 32'd0);
        waitIdle(400, "t1_idle");
        checkRange("t1_strobes", strobe_cnt - base, 3, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_strobe_cmd", strobe_cmd[base + i], vecs[i].cmd);
            if (i > 0) begin
                checkRange("t1_gap", strobe_cyc[base + i] - strobe_cyc[base + i - 1],
                           XFER_CLOCKS + GAP_CYCLES + 3, 100000);
            end
        end
        checkOutput("t1_cmd_held", spiCommand, vecs[2].cmd);
        checkOutput("t1_rbcount", {24'b0, seqStatus[23:16]}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_rbdata", {8'b0, rbData}, {8'b0, vecs[i].rb});
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("t1_rb_empty", {8'b0, rbData}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t1_rbread_empty", {24'b0, seqStatus[23:16]}, 32'd0);

        // Engine never answers: timeout, no readback, next command after gap.
        never_busy = 1'b1;
        base = strobe_cnt;
        applyStimulus(1'b1, 32'hA000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA000_0002, 1'b0, 1'b0);
        waitStrobe(base + 1, 20, "t3_first_strobe");
        checkOutput("t3_no_err_yet", {31'b0, seqStatus[2]}, 32'd0);
        for (int i = 0; i < BUSY_TIMEOUT - 2; i++) step();
        checkOutput("t3_no_err_early", {31'b0, seqStatus[2]}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        checkOutput("t3_timeout_err", {31'b0, seqStatus[2]}, 32'd1);
        waitIdle(200, "t3_idle");
        checkRange("t3_strobes", strobe_cnt - base, 2, 2);
        checkRange("t3_gap", strobe_cyc[base + 1] - strobe_cyc[base],
                   BUSY_TIMEOUT + GAP_CYCLES, BUSY_TIMEOUT + GAP_CYCLES + 4);
        checkOutput("t3_no_readback", {24'b0, seqStatus[23:16]}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("t3_cleared", {31'b0, seqStatus[2]}, 32'd0);
        never_busy = 1'b0;

        // Command FIFO overflow with the sequencer disabled.
        enable = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("t2_cmdcount", {24'b0, seqStatus[15:8]}, 32'(DEPTH));
        checkOutput("t2_cmd_ovf", {31'b0, seqStatus[0]}, 32'd1);
        checkOutput("t2_busy", {31'b0, seqStatus[31]}, 32'd1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        checkOutput("t2_new_event_wins", {31'b0, seqStatus[0]}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("t2_cleared", {31'b0, seqStatus[0]}, 32'd0);
        checkOutput("t2_count_kept", {24'b0, seqStatus[15:8]}, 32'(DEPTH));
        t2base = strobe_cnt;
        enable = 1'b1;
        waitIdle(1200, "t2_drain_idle");
        checkRange("t2_strobes", strobe_cnt - t2base, DEPTH, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t2_contents", strobe_cmd[t2base + i], 32'hC000_0000 + 32'(i));
        end
        checkOutput("t2_rb_full", {24'b0, seqStatus[23:16]}, 32'(DEPTH));
        checkOutput("t2_no_rb_ovf", {31'b0, seqStatus[1]}, 32'd0);

        // Readback FIFO overflow, then a read coinciding with a push.
        base = strobe_cnt;
        applyStimulus(1'b1, 32'hD000_0001, 1'b0, 1'b0);
        waitIdle(200, "t4_idle");
        checkOutput("t4_rb_ovf", {31'b0, seqStatus[1]}, 32'd1);
        checkOutput("t4_rbcount_cap", {24'b0, seqStatus[23:16]}, 32'(DEPTH));
        checkOutput("t4_head", {8'b0, rbData}, {8'b0, rb_table[t2base]});
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_after_read", {24'b0, seqStatus[23:16]}, 32'(DEPTH - 1));
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("t4_ovf_cleared", {31'b0, seqStatus[1]}, 32'd0);
        applyStimulus(1'b1, 32'hD000_0002, 1'b0, 1'b0);
        waitStrobe(base + 2, 20, "t4_second_strobe");
        for (int i = 0; i < 100; i++) begin
            if (!spiStatus[31]) break;
            step();
        end
        step();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_push_pop_count", {24'b0, seqStatus[23:16]}, 32'(DEPTH - 1));
        checkOutput("t4_no_new_ovf", {31'b0, seqStatus[1]}, 32'd0);
        waitIdle(100, "t4_idle2");
        for (int i = 2; i < DEPTH; i++) begin
            checkOutput("t4_drain", {8'b0, rbData}, {8'b0, rb_table[t2base + i]});
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("t4_last", {8'b0, rbData}, {8'b0, rb_table[base + 1]});
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_empty", {8'b0, rbData}, 32'd0);

        // Reset in S_WAIT_DONE with two commands still queued.
        base = strobe_cnt;
        applyStimulus(1'b1, 32'hE000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hE000_0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hE000_0003, 1'b0, 1'b0);
        waitStrobe(base + 1, 20, "t5_first_strobe");
        for (int i = 0; i < 5; i++) step();
        checkOutput("t5_queued", {24'b0, seqStatus[15:8]}, 32'd2);
        stuck_busy = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_status", seqStatus, 32'd0);
        checkOutput("t5_rst_strobe", {31'b0, spiStrobe}, 32'd0);
        checkOutput("t5_rst_command", spiCommand, 32'd0);
        checkOutput("t5_rst_rbdata", {8'b0, rbData}, 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 32'hE000_0004, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step();
        checkRange("t5_no_strobe_while_busy", strobe_cnt - base, 1, 1);
        checkOutput("t5_cmd_waiting", {24'b0, seqStatus[15:8]}, 32'd1);
        stuck_busy = 1'b0;
        waitStrobe(base + 2, 10, "t5_strobe_after_release");
        checkOutput("t5_cmd", strobe_cmd[base + 1], 32'hE000_0004);
        waitIdle(200, "t5_idle");
        checkOutput("t5_rbcount", {24'b0, seqStatus[23:16]}, 32'd1);
        checkOutput("t5_rbdata", {8'b0, rbData}, {8'b0, rb_table[base + 1]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
